alu_cmd_ctrl: RTL and testbench

//  Initiator side of the ALU command interface. Parses an incoming byte stream
//  (from the UART RX path) into ALU operations, drives the alu_en/alu_fun/A/B

---
 rtl/alu_ctrl_pkg.sv | 27 ++
 rtl/alu_cmd_ctrl_if.sv | 32 +++
 rtl/alu_cmd_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command controller: FSM state
// encoding, frame command bytes and the error response byte.
package alu_ctrl_pkg;

  localparam int unsigned FUN_W  = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_OP    = 8'hCC;
  localparam logic [BYTE_W-1:0] CMD_REUSE = 8'hDD;
  localparam logic [BYTE_W-1:0] ERR_BYTE  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    GET_FUN  = 3'd3,
    ALU_REQ  = 3'd4,
    ALU_WAIT = 3'd5,
    SEND     = 3'd6
  } state_e;

  // Frame-collection states accept bytes; everything else is busy.
  function automatic logic is_busy(input state_e s);
    return !(s inside {IDLE, GET_A, GET_B, GET_FUN});
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bundle of the RX byte stream, ALU request/response and TX handshake
// signals seen by the ALU command controller.
interface alu_cmd_ctrl_if #(
  parameter int unsigned dataWidth = 8
);
  import alu_ctrl_pkg::*;

  logic [dataWidth-1:0] rx_data;
  logic                 rx_valid;
  logic [dataWidth-1:0] alu_a;
  logic [dataWidth-1:0] alu_b;
  logic [FUN_W-1:0]     alu_fun;
  logic                 alu_en;
  logic [dataWidth-1:0] alu_res;
  logic                 alu_valid;
  logic [dataWidth-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic                 overrun;

  modport master (
    input  rx_data, rx_valid, alu_res, alu_valid, tx_ready,
    output alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, overrun
  );

  modport slave (
    output rx_data, rx_valid, alu_res, alu_valid, tx_ready,
    input  alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, overrun
  );

endinterface

// File: rtl/alu_cmd_ctrl.sv
// Parses CC/DD command frames into ALU requests and returns the result over a
// valid/ready handshake. Define ALU_CMD_ERR_RESP_EN to emit ERR_BYTE on errors.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned dataWidth = 8,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_cmd_ctrl_if.master bus
);

  localparam int unsigned DW    = dataWidth;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              alu_en_q, alu_en_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  // Next-state and output decode; outputs are derived from state_d so they
  // register in the same cycle the state is entered.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    fun_d     = fun_q;
    tx_data_d = tx_data_q;
    tmo_d     = tmo_q;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == DW'(CMD_OP)) begin
            state_d = GET_A;
          end else if (bus.rx_data == DW'(CMD_REUSE)) begin
            state_d = GET_FUN;
          end else begin
`ifdef ALU_CMD_ERR_RESP_EN
            tx_data_d = DW'(ERR_BYTE);
            state_d   = SEND;
`else
            state_d   = IDLE;
`endif
          end
        end
      end
      GET_A: begin
        if (bus.rx_valid) begin
          a_d     = bus.rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (bus.rx_valid) begin
          b_d     = bus.rx_data;
          state_d = GET_FUN;
        end
      end
      GET_FUN: begin
        if (bus.rx_valid) begin
          fun_d   = bus.rx_data[FUN_W-1:0];
          state_d = ALU_REQ;
        end
      end
      ALU_REQ: begin
        tmo_d   = '0;
        state_d = ALU_WAIT;
      end
      ALU_WAIT: begin
        if (bus.alu_valid) begin
          tx_data_d = bus.alu_res;
          tmo_d     = '0;
          state_d   = SEND;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          tmo_d     = '0;
`ifdef ALU_CMD_ERR_RESP_EN
          tx_data_d = DW'(ERR_BYTE);
          state_d   = SEND;
`else
          state_d   = IDLE;
`endif
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    alu_en_d   = (state_d == ALU_REQ);
    tx_valid_d = (state_d == SEND);
    busy_d     = is_busy(state_d);
    overrun_d  = bus.rx_valid && is_busy(state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      alu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      alu_en_q   <= alu_en_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_fun  = fun_q;
  assign bus.alu_en   = alu_en_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small behavioural ALU
// (0 add, 1 sub, 2 mul, 3 div) answering one cycle after alu_en.
module tb_alu_cmd_ctrl;
  import alu_ctrl_pkg::*;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_ctrl_if #(.dataWidth(DW)) bus ();

  alu_cmd_ctrl #(.dataWidth(DW), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit alu_stall;
  logic pend;

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return DW'(a * b);
      4'd3:    return (b != '0) ? a / b : '0;
      default: return '0;
    endcase
  endfunction

  // Behavioural ALU: result latched on alu_en, out_valid one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_valid <= 1'b0;
      bus.alu_res   <= '0;
      pend          <= 1'b0;
    end else begin
      bus.alu_valid <= 1'b0;
      if (bus.alu_en && !alu_stall) begin
        pend        <= 1'b1;
        bus.alu_res <= alu_f(bus.alu_a, bus.alu_b, bus.alu_fun);
      end else if (pend) begin
        bus.alu_valid <= 1'b1;
        pend          <= 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [DW-1:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept_tx();
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en, bus.tx_data, bus.tx_valid,
         bus.busy, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h fun=%h en=%b txd=%h txv=%b busy=%b ovr=%b want all 0",
               bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en, bus.tx_data, bus.tx_valid,
               bus.busy, bus.overrun);
    end
  endtask

  task automatic test_op_frame();
    bit ok;
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    n_checks++;
    if ({bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_fun} !== {1'b1, 8'h05, 8'h03, 4'h0}) begin
      n_fail++;
      $display("FAIL op_req: got en=%b a=%h b=%h fun=%h want en=1 a=05 b=03 fun=0",
               bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_fun);
    end
    @(negedge clk);
    n_checks++;
    if (bus.alu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL op_en_pulse: got en=%b want 0", bus.alu_en);
    end
    wait_tx(ok);
    n_checks++;
    if (!ok || bus.tx_data !== 8'h08 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL op_result: got txv=%b txd=%h busy=%b want txv=1 txd=08 busy=1",
               bus.tx_valid, bus.tx_data, bus.busy);
    end
    accept_tx();
    n_checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL op_done: got txv=%b busy=%b want 0 0", bus.tx_valid, bus.busy);
    end
  endtask

  task automatic test_reuse();
    bit ok;
    send_byte(8'hDD); send_byte(8'hF2);
    n_checks++;
    if ({bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_fun} !== {1'b1, 8'h05, 8'h03, 4'h2}) begin
      n_fail++;
      $display("FAIL reuse_req: got en=%b a=%h b=%h fun=%h want en=1 a=05 b=03 fun=2",
               bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_fun);
    end
    wait_tx(ok);
    n_checks++;
    if (!ok || bus.tx_data !== 8'h0F) begin
      n_fail++;
      $display("FAIL reuse_result: got txv=%b txd=%h want txv=1 txd=0f", bus.tx_valid, bus.tx_data);
    end
    accept_tx();
    n_checks++;
    if (bus.alu_a !== 8'h05) begin
      n_fail++;
      $display("FAIL reuse_a_hold: got a=%h want 05", bus.alu_a);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    send_byte(8'hCC); send_byte(8'h09); send_byte(8'h04); send_byte(8'h01);
    wait_tx(ok);
    stable = ok;
    for (int i = 0; i < 5; i++) begin
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h05 || bus.busy !== 1'b1) stable = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_stable: got txv=%b txd=%h busy=%b want held 1 05 1 for 5 cycles",
               bus.tx_valid, bus.tx_data, bus.busy);
    end
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h05) begin
      n_fail++;
      $display("FAIL bp_ready_cycle: got txv=%b txd=%h want 1 05", bus.tx_valid, bus.tx_data);
    end
    accept_tx();
    n_checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got txv=%b busy=%b want 0 0", bus.tx_valid, bus.busy);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h02); send_byte(8'h00);
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_idle: got ovr=%b want 0", bus.overrun);
    end
    @(negedge clk);
    bus.rx_data  = 8'h11;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_pulse: got ovr=%b want 1", bus.overrun);
    end
    @(negedge clk);
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_one_cycle: got ovr=%b want 0", bus.overrun);
    end
    wait_tx(ok);
    n_checks++;
    if (!ok || bus.tx_data !== 8'h09 || bus.alu_a !== 8'h07) begin
      n_fail++;
      $display("FAIL ovr_result: got txv=%b txd=%h a=%h want 1 09 07", bus.tx_valid, bus.tx_data, bus.alu_a);
    end
    accept_tx();
  endtask

  task automatic test_unknown_cmd();
    bit ok;
    bit seen;
    send_byte(8'h42);
`ifdef ALU_CMD_ERR_RESP_EN
    wait_tx(ok);
    n_checks++;
    if (!ok || bus.tx_data !== 8'hEE) begin
      n_fail++;
      $display("FAIL unk_err: got txv=%b txd=%h want 1 ee", bus.tx_valid, bus.tx_data);
    end
    accept_tx();
`else
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL unk_ignored: got txv=%b busy=%b want 0 0", bus.tx_valid, bus.busy);
    end
`endif
    send_byte(8'hDD); send_byte(8'h00);
    n_checks++;
    if (bus.alu_en !== 1'b1 || bus.alu_fun !== 4'h0) begin
      n_fail++;
      $display("FAIL unk_then_idle: got en=%b fun=%h want 1 0", bus.alu_en, bus.alu_fun);
    end
    wait_tx(ok);
    n_checks++;
    if (!ok || bus.tx_data !== 8'h09) begin
      n_fail++;
      $display("FAIL unk_then_result: got txv=%b txd=%h want 1 09", bus.tx_valid, bus.tx_data);
    end
    accept_tx();
  endtask

  task automatic test_timeout();
    bit held;
    alu_stall = 1'b1;
    send_byte(8'hDD); send_byte(8'h01);
    n_checks++;
    if (bus.alu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_req: got en=%b want 1", bus.alu_en);
    end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.busy !== 1'b1 || bus.tx_valid !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL tmo_wait: got busy=%b txv=%b want busy 1 txv 0 for 5 cycles", bus.busy, bus.tx_valid);
    end
`ifdef ALU_CMD_ERR_RESP_EN
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hEE) begin
      n_fail++;
      $display("FAIL tmo_abort: got txv=%b txd=%h want 1 ee", bus.tx_valid, bus.tx_data);
    end
    accept_tx();
`else
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_abort: got busy=%b txv=%b want 0 0", bus.busy, bus.tx_valid);
    end
`endif
    alu_stall = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    send_byte(8'hCC); send_byte(8'h33);
    n_checks++;
    if (bus.alu_a !== 8'h33) begin
      n_fail++;
      $display("FAIL rst_pre_a: got a=%h want 33", bus.alu_a);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en, bus.tx_data, bus.tx_valid,
         bus.busy, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got a=%h b=%h fun=%h en=%b txd=%h txv=%b busy=%b want all 0",
               bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en, bus.tx_data, bus.tx_valid, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'hDD); send_byte(8'h00);
    n_checks++;
    if ({bus.alu_en, bus.alu_a, bus.alu_b} !== {1'b1, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_idle: got en=%b a=%h b=%h want 1 00 00", bus.alu_en, bus.alu_a, bus.alu_b);
    end
    wait_tx(ok);
    n_checks++;
    if (!ok || bus.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_result: got txv=%b txd=%h want 1 00", bus.tx_valid, bus.tx_data);
    end
    accept_tx();
  endtask

  initial begin
    rst          = 1'b1;
    alu_stall    = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_op_frame();
    test_reuse();
    test_backpressure();
    test_overrun();
    test_unknown_cmd();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
